// File: rtl/bit_packer.sv
// -----------------------------------------------------------------------------
// bit_packer
//
// Takes variable-length codes (0-16 bits per cycle) and packs them MSB-first
// into a continuous bitstream. The stream leaves as 16-bit words through a
// small show-ahead output FIFO with valid/ready handshaking. A flush request
// pads the last partial word, emits it, waits for the FIFO to drain and then
// pulses FlushDone.
//
// Optional feature: define BIT_PACKER_STOP_BIT_EN to make the flush append a
// single '1' stop bit before the zero fill. With this enabled a flush always
// emits a word, even when no bits are pending. Without it the flush only
// zero-fills, and emits nothing when no bits are pending.
//
// Parameters:
//   FIFO_DEPTH   output FIFO depth in 16-bit words (power of 2, >= 2)
//
// Ports:
//   Clk          clock, sole clock domain
//   Reset        synchronous, active-high reset
//   Enable       module enable; low clears all state on the clock edge
//   Code         right-justified code bits; the low CodeLen bits are used
//   CodeLen      code length 0-16; values 17-31 are treated as 16
//   CodeValid    Code/CodeLen valid
//   CodeReady    code accepted when CodeValid & CodeReady
//   Flush        request to pad and emit the final partial word
//   FlushDone    one-cycle pulse: flush complete and FIFO empty
//   WordOut      packed word; the first bit of the stream is in bit 15
//   WordValid    WordOut valid
//   WordReady    sink accepts the word when WordValid & WordReady
//   BitsPending  number of bits held in the accumulator (0-15)
// -----------------------------------------------------------------------------
module bit_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [15:0] Code,
    input  logic [4:0]  CodeLen,
    input  logic        CodeValid,
    output logic        CodeReady,
    input  logic        Flush,
    output logic        FlushDone,
    output logic [15:0] WordOut,
    output logic        WordValid,
    input  logic        WordReady,
    output logic [4:0]  BitsPending
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_PAD,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic          clr;
    logic          fifo_full, fifo_empty;
    logic          accept, push, pop;
    logic [15:0]   push_word;
    logic [4:0]    len;
    logic [15:0]   mask, masked;
    logic [5:0]    sh, sum;
    logic [31:0]   placed, acc_ins;
    logic          pad_has_word;
    logic [15:0]   pad_word;

    assign clr        = Reset | ~Enable;
    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Conservative: a pop in the same cycle does not reopen the input.
    assign CodeReady   = Enable & ~Reset & (state_q == S_RUN) & ~fifo_full;
    assign accept      = CodeValid & CodeReady;
    assign WordValid   = ~fifo_empty;
    assign WordOut     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign pop         = WordValid & WordReady;
    assign FlushDone   = done_q;
    assign BitsPending = cnt_q;

    // Code alignment: the masked code lands at acc[31-cnt -: len], i.e. it is
    // shifted up so that its LSB sits at bit (32 - cnt - len). Since
    // cnt <= 15 and len <= 16 the shift is always between 1 and 32.
    always_comb begin
        len     = (CodeLen > 5'd16) ? 5'd16 : CodeLen;
        mask    = (len == 5'd16) ? 16'hFFFF : ((16'd1 << len) - 16'd1);
        masked  = Code & mask;
        sh      = 6'd32 - {1'b0, cnt_q} - {1'b0, len};
        placed  = {16'h0000, masked} << sh;
        acc_ins = acc_q | placed;
        sum     = {1'b0, cnt_q} + {1'b0, len};
    end

    // Bits below the pending count are always zero, so the top half of the
    // accumulator is already the zero-filled word.
`ifdef BIT_PACKER_STOP_BIT_EN
    assign pad_has_word = 1'b1;
    assign pad_word     = acc_q[31:16] | (16'h8000 >> cnt_q);
`else
    assign pad_has_word = (cnt_q != 5'd0);
    assign pad_word     = acc_q[31:16];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_word = 16'h0000;
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (sum >= 6'd16) begin
                        push      = 1'b1;
                        push_word = acc_ins[31:16];
                        acc_d     = {acc_ins[15:0], 16'h0000};
                        cnt_d     = 5'(sum - 6'd16);
                    end else begin
                        acc_d = acc_ins;
                        cnt_d = sum[4:0];
                    end
                end
                // Any code accepted this cycle is appended before the flush.
                if (Flush) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (!pad_has_word) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (!fifo_full) begin
                    push      = 1'b1;
                    push_word = pad_word;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (clr) begin
            state_q  <= S_RUN;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_bit_packer
//
// Self-checking bench for bit_packer. The reference model keeps the stream as
// a queue of individual bits and cuts it into 16-bit words. Words taken by
// the sink are collected on the falling clock edge and compared in order
// against the model's word queue.
// -----------------------------------------------------------------------------
module tb_bit_packer;

    localparam int FIFO_DEPTH = 4;

`ifdef BIT_PACKER_STOP_BIT_EN
    localparam logic [15:0] EXP_FLUSH_TAIL = 16'hF000;
    localparam logic [15:0] EXP_SAME_CYC   = 16'hE000;
    localparam logic [15:0] EXP_REENABLE   = 16'hA800;
`else
    localparam logic [15:0] EXP_FLUSH_TAIL = 16'hE000;
    localparam logic [15:0] EXP_SAME_CYC   = 16'hC000;
    localparam logic [15:0] EXP_REENABLE   = 16'hA000;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [15:0] Code = '0;
    logic [4:0]  CodeLen = '0;
    logic        CodeValid = 1'b0;
    logic        CodeReady;
    logic        Flush = 1'b0;
    logic        FlushDone;
    logic [15:0] WordOut;
    logic        WordValid;
    logic        WordReady = 1'b0;
    logic [4:0]  BitsPending;

    int checks = 0;
    int errors = 0;

    bit          mbits[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          done_count = 0;
    int          done_got_size = 0;
    bit          rnd_mode = 1'b0;

    bit_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .Code       (Code),
        .CodeLen    (CodeLen),
        .CodeValid  (CodeValid),
        .CodeReady  (CodeReady),
        .Flush      (Flush),
        .FlushDone  (FlushDone),
        .WordOut    (WordOut),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .BitsPending(BitsPending)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WordValid && WordReady) got_q.push_back(WordOut);
        if (FlushDone) begin
            done_count    <= done_count + 1;
            done_got_size <= got_q.size();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_accept(input logic [15:0] c, input int l);
        int n;
        logic [15:0] w;
        n = (l > 16) ? 16 : l;
        for (int i = n - 1; i >= 0; i--) mbits.push_back(c[i]);
        while (mbits.size() >= 16) begin
            for (int i = 15; i >= 0; i--) w[i] = mbits.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_flush();
        logic [15:0] w;
`ifdef BIT_PACKER_STOP_BIT_EN
        mbits.push_back(1'b1);
`endif
        if (mbits.size() > 0) begin
            while (mbits.size() < 16) mbits.push_back(1'b0);
            for (int i = 15; i >= 0; i--) w[i] = mbits.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_code(input logic [15:0] c, input logic [4:0] l);
        int n = 0;
        Code      = c;
        CodeLen   = l;
        CodeValid = 1'b1;
        while (!CodeReady && n < 300) begin
            if (rnd_mode && n >= 8) WordReady = 1'b1;
            step();
            n++;
        end
        if (!CodeReady) begin
            checks++;
            errors++;
            $display("FAIL code_accept_timeout: CodeReady=%0b after %0d cycles, required 1", CodeReady, n);
            CodeValid = 1'b0;
        end else begin
            model_accept(c, int'(l));
            step();
            CodeValid = 1'b0;
            checks++;
            if (BitsPending !== 5'(mbits.size())) begin
                errors++;
                $display("FAIL bits_pending: got %0d, expected %0d", BitsPending, mbits.size());
            end
        end
    endtask

    task automatic pulse_flush();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        model_flush();
    endtask

    task automatic wait_done(input string name);
        int start = done_count;
        int n = 0;
        WordReady = 1'b1;
        while (done_count == start && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (done_count == start) begin
            errors++;
            $display("FAIL %s_flushdone_timeout: no FlushDone after %0d cycles", name, n);
        end else begin
            checks++;
            if (done_got_size != exp_q.size()) begin
                errors++;
                $display("FAIL %s_flushdone_early: words popped at pulse %0d, expected %0d",
                         name, done_got_size, exp_q.size());
            end
        end
        repeat (5) step();
        checks++;
        if (done_count != start + 1) begin
            errors++;
            $display("FAIL %s_flushdone_count: got %0d pulses, expected 1", name, done_count - start);
        end
    endtask

    task automatic check_stream(input string name);
        int n = 0;
        int m;
        WordReady = 1'b1;
        while ((got_q.size() < exp_q.size() || WordValid) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_word_count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
        end
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_word[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset  = 1'b1;
        Enable = 1'b1;
        repeat (2) step();
        checks += 5;
        if (WordValid !== 1'b0) begin errors++; $display("FAIL reset_wordvalid: got %b, expected 0", WordValid); end
        if (WordOut !== 16'h0) begin errors++; $display("FAIL reset_wordout: got %h, expected 0000", WordOut); end
        if (BitsPending !== 5'd0) begin errors++; $display("FAIL reset_bitspending: got %0d, expected 0", BitsPending); end
        if (FlushDone !== 1'b0) begin errors++; $display("FAIL reset_flushdone: got %b, expected 0", FlushDone); end
        if (CodeReady !== 1'b0) begin errors++; $display("FAIL reset_codeready: got %b, expected 0", CodeReady); end
        Reset = 1'b0;
        #1;
        checks++;
        if (CodeReady !== 1'b1) begin errors++; $display("FAIL run_codeready: got %b, expected 1", CodeReady); end
    endtask

    task automatic test_basic();
        WordReady = 1'b1;
        send_code(16'h00AB, 5'd8);
        send_code(16'h00CD, 5'd8);
        checks += 2;
        if (WordValid !== 1'b1) begin errors++; $display("FAIL basic_wordvalid: got %b, expected 1", WordValid); end
        if (WordOut !== 16'hABCD) begin errors++; $display("FAIL basic_wordout: got %h, expected abcd", WordOut); end
        check_stream("basic");
    endtask

    task automatic test_flush();
        send_code(16'h0005, 5'd3);
        send_code(16'hFFFF, 5'd16);
        pulse_flush();
        wait_done("flush");
        checks += 2;
        if (got_q.size() < 2 || got_q[0] !== 16'hBFFF) begin
            errors++; $display("FAIL flush_word0: got %h, expected bfff", (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        if (got_q.size() < 2 || got_q[1] !== EXP_FLUSH_TAIL) begin
            errors++; $display("FAIL flush_word1: got %h, expected %h", (got_q.size() > 1) ? got_q[1] : 16'hxxxx, EXP_FLUSH_TAIL);
        end
        check_stream("flush");
    endtask

    task automatic test_backpressure();
        WordReady = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) send_code(16'($urandom), 5'd16);
        checks += 3;
        if (CodeReady !== 1'b0) begin errors++; $display("FAIL bp_codeready_full: got %b, expected 0", CodeReady); end
        if (WordValid !== 1'b1) begin errors++; $display("FAIL bp_wordvalid: got %b, expected 1", WordValid); end
        if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d words, expected 0", got_q.size()); end
        repeat (3) step();
        checks++;
        if (CodeReady !== 1'b0) begin errors++; $display("FAIL bp_codeready_held: got %b, expected 0", CodeReady); end
        WordReady = 1'b1;
        send_code(16'($urandom), 5'd16);
        check_stream("backpressure");
    endtask

    task automatic test_len0_clamp();
        WordReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_code(16'($urandom), 5'd0);
            send_code(16'h0001, 5'd1);
        end
        send_code(16'h1234, 5'd20);
        checks += 2;
        if (got_q.size() < 1 || got_q[0] !== 16'hFFFF) begin
            errors++; $display("FAIL len0_word: got %h, expected ffff", (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        end
        repeat (2) step();
        if (got_q.size() < 2 || got_q[1] !== 16'h1234) begin
            errors++; $display("FAIL clamp_word: got %h, expected 1234", (got_q.size() > 1) ? got_q[1] : 16'hxxxx);
        end
        check_stream("len0_clamp");
    endtask

    task automatic test_flush_same_cycle();
        WordReady = 1'b1;
        Code      = 16'h0003;
        CodeLen   = 5'd2;
        CodeValid = 1'b1;
        Flush     = 1'b1;
        checks++;
        if (CodeReady !== 1'b1) begin errors++; $display("FAIL samecyc_codeready: got %b, expected 1", CodeReady); end
        step();
        CodeValid = 1'b0;
        Flush     = 1'b0;
        model_accept(16'h0003, 2);
        model_flush();
        wait_done("samecyc");
        checks++;
        if (got_q.size() < 1 || got_q[0] !== EXP_SAME_CYC) begin
            errors++; $display("FAIL samecyc_word: got %h, expected %h", (got_q.size() > 0) ? got_q[0] : 16'hxxxx, EXP_SAME_CYC);
        end
        check_stream("samecyc");
    endtask

    task automatic test_enable_drop();
        int start;
        WordReady = 1'b0;
        send_code(16'($urandom), 5'd16);
        send_code(16'h0003, 5'd4);
        pulse_flush();
        repeat (3) step();
        checks++;
        if (WordValid !== 1'b1) begin errors++; $display("FAIL endrop_queued: got WordValid %b, expected 1", WordValid); end
        start  = done_count;
        Enable = 1'b0;
        step();
        checks += 4;
        if (WordValid !== 1'b0) begin errors++; $display("FAIL endrop_wordvalid: got %b, expected 0", WordValid); end
        if (WordOut !== 16'h0) begin errors++; $display("FAIL endrop_wordout: got %h, expected 0000", WordOut); end
        if (BitsPending !== 5'd0) begin errors++; $display("FAIL endrop_bitspending: got %0d, expected 0", BitsPending); end
        if (CodeReady !== 1'b0) begin errors++; $display("FAIL endrop_codeready: got %b, expected 0", CodeReady); end
        mbits.delete();
        exp_q.delete();
        got_q.delete();
        Enable    = 1'b1;
        WordReady = 1'b1;
        repeat (5) step();
        checks += 2;
        if (done_count != start) begin errors++; $display("FAIL endrop_flushdone: got %0d pulses, expected 0", done_count - start); end
        if (got_q.size() != 0) begin errors++; $display("FAIL endrop_stale_words: got %0d words, expected 0", got_q.size()); end
        send_code(16'h000A, 5'd4);
        pulse_flush();
        wait_done("reenable");
        checks++;
        if (got_q.size() < 1 || got_q[0] !== EXP_REENABLE) begin
            errors++; $display("FAIL reenable_word: got %h, expected %h", (got_q.size() > 0) ? got_q[0] : 16'hxxxx, EXP_REENABLE);
        end
        check_stream("reenable");
    endtask

    task automatic test_random();
        rnd_mode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 60; k++) begin
                WordReady = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) step();
                send_code(16'($urandom), 5'($urandom_range(0, 20)));
            end
            pulse_flush();
            wait_done("random");
            check_stream("random");
        end
        rnd_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_len0_clamp();
        test_flush_same_cycle();
        test_enable_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
